// File: rtl/load_align.sv
// Load formatter: issues one word read per accepted load, then byte/halfword-aligns and extends the result.
// Optional LOAD_MISALIGN_CHECK_EN flags misaligned LH/LHU/LW and zeroes their data.
module load_align #(
    parameter int W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       addr,
    input  logic [2:0]        func3,
    output logic              mem_en,
    output logic [13:0]       mem_addr,
    input  logic [W_SIZE-1:0] mem_dout,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W_SIZE-1:0] load_data,
    output logic              load_misaligned
);

    localparam logic [2:0] F_LB  = 3'd0;
    localparam logic [2:0] F_LH  = 3'd1;
    localparam logic [2:0] F_LW  = 3'd2;
    localparam logic [2:0] F_LBU = 3'd4;
    localparam logic [2:0] F_LHU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        addr_lo_reg;
    logic [2:0]        func3_reg;
    logic [W_SIZE-1:0] load_data_reg, load_data_next;
    logic              misaligned_reg, misaligned_next;
    logic              accept;
    logic [7:0]        lane [4];
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_dout[8*gi +: 8];
        end
    endgenerate

    assign mem_addr        = addr[15:2];
    assign load_data       = load_data_reg;
    assign load_misaligned = misaligned_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: req_ready = 1'b1;
            WAIT: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Nothing is handed out or accepted while reset is being applied.
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
        end
        accept = req_valid && req_ready;
        mem_en = accept;
        if (accept)
            state_next = WAIT;
    end

    always_comb begin
        byte_sel        = lane[addr_lo_reg];
        half_sel        = addr_lo_reg[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
        load_data_next  = '0;
        misaligned_next = 1'b0;
        case (func3_reg)
            F_LB:    load_data_next = {{(W_SIZE-8){byte_sel[7]}}, byte_sel};
            F_LH:    load_data_next = {{(W_SIZE-16){half_sel[15]}}, half_sel};
            F_LW:    load_data_next = mem_dout;
            F_LBU:   load_data_next = {{(W_SIZE-8){1'b0}}, byte_sel};
            F_LHU:   load_data_next = {{(W_SIZE-16){1'b0}}, half_sel};
            default: load_data_next = '0;
        endcase
`ifdef LOAD_MISALIGN_CHECK_EN
        if (((func3_reg == F_LH || func3_reg == F_LHU) && addr_lo_reg[0]) ||
            (func3_reg == F_LW && addr_lo_reg != 2'b00)) begin
            misaligned_next = 1'b1;
            load_data_next  = '0;
        end
`else
        misaligned_next = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_lo_reg    <= 2'b00;
            func3_reg      <= 3'd0;
            load_data_reg  <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_lo_reg <= addr[1:0];
                func3_reg   <= func3;
            end
            // Result is captured only in WAIT, so it stays frozen through RESP stalls.
            if (state_reg == WAIT) begin
                load_data_reg  <= load_data_next;
                misaligned_reg <= misaligned_next;
            end
        end
    end

endmodule

// File: tb/tb_load_align.sv
// Randomized and directed bench for load_align with a transaction-level reference model.
module tb_load_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] addr = '0;
    logic [2:0]  func3 = '0;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_dout = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] load_data;
    logic        load_misaligned;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int mem_en_cnt = 0;
    int resp_cnt = 0;

    logic [31:0] mem [16384];

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          due;
    } exp_t;
    exp_t pending[$];

    load_align #(.W_SIZE(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .func3(func3), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .load_data(load_data), .load_misaligned(load_misaligned)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after mem_en, garbage otherwise.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
        else        mem_dout <= $urandom;
    end

    function automatic void model(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f,
                                  output logic [31:0] d, output logic m);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = a[1] ? (w >> 16) : (w & 32'hFFFF);
        m = 1'b0;
        case (f)
            3'd0: d = (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd1: d = (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd2: d = w;
            3'd4: d = b;
            3'd5: d = h;
            default: d = 32'h0;
        endcase
`ifdef LOAD_MISALIGN_CHECK_EN
        if (((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a != 2'b00)) begin
            d = 32'h0;
            m = 1'b1;
        end
`endif
    endfunction

    task automatic step(input logic rv, input logic [15:0] a, input logic [2:0] f, input logic rr);
        logic ev, er;
        exp_t e;
        @(negedge clk);
        rst = 1'b0; req_valid = rv; addr = a; func3 = f; resp_ready = rr;
        #1;
        ev = (pending.size() > 0) && (cycle >= pending[0].due);
        er = (pending.size() == 0) || (ev && rr);
        tests++;
        if (resp_valid !== ev) begin
            fails++;
            $display("FAIL resp_valid cyc=%0d: got %b expected %b", cycle, resp_valid, ev);
        end
        tests++;
        if (req_ready !== er) begin
            fails++;
            $display("FAIL req_ready cyc=%0d: got %b expected %b", cycle, req_ready, er);
        end
        tests++;
        if (mem_en !== (rv && er)) begin
            fails++;
            $display("FAIL mem_en cyc=%0d: got %b expected %b", cycle, mem_en, rv && er);
        end
        if (rv && er) begin
            tests++;
            if (mem_addr !== a[15:2]) begin
                fails++;
                $display("FAIL mem_addr cyc=%0d: got %h expected %h", cycle, mem_addr, a[15:2]);
            end
        end
        if (ev) begin
            tests++;
            if (load_data !== pending[0].data) begin
                fails++;
                $display("FAIL load_data cyc=%0d: got %h expected %h", cycle, load_data, pending[0].data);
            end
            tests++;
            if (load_misaligned !== pending[0].mis) begin
                fails++;
                $display("FAIL load_misaligned cyc=%0d: got %b expected %b", cycle, load_misaligned, pending[0].mis);
            end
        end
        if (mem_en) mem_en_cnt++;
        if (ev && rr) begin
            $display("[TB] cyc=%0d resp data=%h mis=%b", cycle, load_data, load_misaligned);
            resp_cnt++;
            void'(pending.pop_front());
        end
        if (rv && er) begin
            model(mem[a[15:2]], a[1:0], f, e.data, e.mis);
            e.due = cycle + 2;
            pending.push_back(e);
        end
        cycle++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; addr = 16'h0004; func3 = 3'd2; resp_ready = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (req_ready !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b en=%b vld=%b expected 0 0 0", req_ready, mem_en, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || load_data !== 32'h0 || load_misaligned !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got rdy=%b vld=%b data=%h mis=%b expected 1 0 0 0",
                     req_ready, resp_valid, load_data, load_misaligned);
        end
        $display("[TB] reset checked");
        pending.delete();
    endtask

    task automatic test_byte_half();
        mem[0] = 32'h80FF_7F01;
        step(1'b1, 16'h0003, 3'd0, 1'b1);      // LB -> FFFFFF80
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b1, 16'h0001, 3'd4, 1'b1);      // LBU -> 7F
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b1, 16'h0002, 3'd5, 1'b1);      // LHU -> 80FF
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    task automatic test_stall();
        mem[0] = 32'h80FF_7F01;
        step(1'b1, 16'h0002, 3'd1, 1'b0);      // LH -> FFFF80FF
        step(1'b1, 16'h0000, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0008, 3'd2, 1'b0);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int en0, r0;
        en0 = mem_en_cnt; r0 = resp_cnt;
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom) & 16'hFFFC, 3'd2, 1'b1);
        tests++;
        if (mem_en_cnt - en0 != 5) begin
            fails++;
            $display("FAIL b2b_mem_en_count: got %0d expected 5", mem_en_cnt - en0);
        end
        tests++;
        if (resp_cnt - r0 != 4) begin
            fails++;
            $display("FAIL b2b_resp_count: got %0d expected 4", resp_cnt - r0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    task automatic test_reset_in_wait();
        mem[1] = 32'h1234_5678;
        step(1'b1, 16'h0004, 3'd2, 1'b1);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_wait: got vld=%b rdy=%b expected 0 0", resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || load_data !== 32'h0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL after_rst_in_wait: got vld=%b data=%h rdy=%b expected 0 0 1",
                     resp_valid, load_data, req_ready);
        end
        $display("[TB] reset in WAIT checked");
        pending.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    task automatic test_misaligned();
        mem[1] = 32'hCAFE_BABE;
        step(1'b1, 16'h0006, 3'd2, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b1, 16'h0005, 3'd1, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 3'd0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        test_reset();
        test_byte_half();
        test_stall();
        test_back_to_back();
        test_reset_in_wait();
        test_misaligned();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
